// File: rtl/vram_arbiter.sv
// Single-port arbiter for the shared video/sprite RAM: sprite > tile > CPU,
// with a starvation guard that lets a long-waiting CPU preempt the tile fetcher.
module vram_arbiter #(
  parameter int AW           = 16,
  parameter int DW           = 8,
  parameter int STARVE_LIMIT = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          spr_req,
  input  logic [AW-1:0] spr_addr,
  output logic          spr_gnt,
  output logic          spr_rvalid,
  input  logic          til_req,
  input  logic [AW-1:0] til_addr,
  output logic          til_gnt,
  output logic          til_rvalid,
  output logic          til_drop,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_wait,
  output logic          cpu_rvalid,
  output logic [DW-1:0] rdata,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_din
);

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_SPR,
    OWN_TIL,
    OWN_CPU
  } owner_t;

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  owner_t     owner_q;
  owner_t     owner_d;
  logic [7:0] starve_cnt;
  logic       starved;

  assign starved = (starve_cnt == LIMIT);

  // The sprite loader always wins; a starved CPU outranks the tile fetcher.
  always_comb begin
    spr_gnt  = 1'b0;
    til_gnt  = 1'b0;
    cpu_gnt  = 1'b0;
    til_drop = 1'b0;
    if (!rst) begin
      spr_gnt = spr_req;
      if (!spr_req) begin
        if (cpu_req && starved) begin
          cpu_gnt  = 1'b1;
          til_drop = til_req;
        end else if (til_req) begin
          til_gnt = 1'b1;
        end else if (cpu_req) begin
          cpu_gnt = 1'b1;
        end
      end
    end
  end

  assign cpu_wait = cpu_req & ~cpu_gnt;

  always_comb begin
    ram_addr  = '0;
    ram_wdata = '0;
    owner_d   = OWN_NONE;
    if (spr_gnt) begin
      ram_addr = spr_addr;
      owner_d  = OWN_SPR;
    end else if (til_gnt) begin
      ram_addr = til_addr;
      owner_d  = OWN_TIL;
    end else if (cpu_gnt) begin
      ram_addr  = cpu_addr;
      ram_wdata = cpu_wdata;
      owner_d   = cpu_we ? OWN_NONE : OWN_CPU;
    end
  end

  assign ram_en = spr_gnt | til_gnt | cpu_gnt;
  assign ram_we = cpu_gnt & cpu_we;

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q    <= OWN_NONE;
      starve_cnt <= '0;
    end else begin
      owner_q <= owner_d;
      if (cpu_req && !cpu_gnt) begin
        if (!starved) starve_cnt <= starve_cnt + 8'd1;
      end else begin
        starve_cnt <= '0;
      end
    end
  end

  // Gating with rst kills a return whose grant was followed by a reset cycle.
  assign spr_rvalid = ~rst & (owner_q == OWN_SPR);
  assign til_rvalid = ~rst & (owner_q == OWN_TIL);
  assign cpu_rvalid = ~rst & (owner_q == OWN_CPU);
  assign rdata      = ram_din;

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: directed scenarios plus a randomized
// run compared against a winner-picking reference model and shadow RAM.
module tb_vram_arbiter;

  localparam int AW    = 16;
  localparam int DW    = 8;
  localparam int LIMIT = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          spr_req, til_req, cpu_req, cpu_we;
  logic [AW-1:0] spr_addr, til_addr, cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          spr_gnt, spr_rvalid, til_gnt, til_rvalid, til_drop;
  logic          cpu_gnt, cpu_wait, cpu_rvalid;
  logic [DW-1:0] rdata, ram_wdata, ram_din;
  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addr;

  logic [DW-1:0] mem     [0:65535];
  logic [DW-1:0] ref_mem [0:65535];

  int total = 0;
  int bad   = 0;

  vram_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .spr_req(spr_req), .spr_addr(spr_addr), .spr_gnt(spr_gnt), .spr_rvalid(spr_rvalid),
    .til_req(til_req), .til_addr(til_addr), .til_gnt(til_gnt), .til_rvalid(til_rvalid),
    .til_drop(til_drop),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_wait(cpu_wait), .cpu_rvalid(cpu_rvalid),
    .rdata(rdata), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_din(ram_din)
  );

  always #5 clk = ~clk;

  // RAM macro with one-cycle read latency.
  always @(posedge clk) begin
    if (ram_en && ram_we) mem[ram_addr] <= ram_wdata;
    if (ram_en && !ram_we) ram_din <= mem[ram_addr];
  end

  task automatic drive(input logic s, input logic t, input logic c, input logic we,
                       input logic [AW-1:0] sa, input logic [AW-1:0] ta,
                       input logic [AW-1:0] ca, input logic [DW-1:0] wd);
    spr_req = s; til_req = t; cpu_req = c; cpu_we = we;
    spr_addr = sa; til_addr = ta; cpu_addr = ca; cpu_wdata = wd;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1, 1, 1, 0, 16'h0010, 16'h0020, 16'h0030, 8'h00);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); #1;
      total++;
      if ({spr_gnt, til_gnt, cpu_gnt, ram_en, ram_we, til_drop, cpu_wait} !== 7'b0000001) begin
        bad++;
        $display("[TB] FAIL reset_outputs: got %b want 0000001",
                 {spr_gnt, til_gnt, cpu_gnt, ram_en, ram_we, til_drop, cpu_wait});
      end
      total++;
      if ({spr_rvalid, til_rvalid, cpu_rvalid} !== 3'b000) begin
        bad++;
        $display("[TB] FAIL reset_rvalid: got %b want 000", {spr_rvalid, til_rvalid, cpu_rvalid});
      end
    end
    rst = 1'b0; #1;
    total++;
    if (spr_gnt !== 1'b1 || cpu_wait !== 1'b1) begin
      bad++;
      $display("[TB] FAIL reset_release: spr_gnt=%b cpu_wait=%b want 1 1", spr_gnt, cpu_wait);
    end
  endtask

  task automatic test_priority();
    @(negedge clk);
    drive(1, 1, 1, 0, 16'h5060, 16'h0022, 16'h4000, 8'h00); #1;
    total++;
    if ({spr_gnt, til_gnt, cpu_gnt, til_drop, cpu_wait} !== 5'b10001 || ram_addr !== 16'h5060) begin
      bad++;
      $display("[TB] FAIL priority_grant: got %b addr %h want 10001 addr 5060",
               {spr_gnt, til_gnt, cpu_gnt, til_drop, cpu_wait}, ram_addr);
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0); #1;
    total++;
    if ({spr_rvalid, til_rvalid, cpu_rvalid} !== 3'b100 || rdata !== ref_mem[16'h5060]) begin
      bad++;
      $display("[TB] FAIL priority_return: rvalid %b rdata %h want 100 %h",
               {spr_rvalid, til_rvalid, cpu_rvalid}, rdata, ref_mem[16'h5060]);
    end
    @(negedge clk);
  endtask

  task automatic test_starvation();
    drive(0, 1, 1, 0, 0, 16'h0100, 16'h4000, 8'h00);
    for (int k = 1; k <= LIMIT; k++) begin
      #1;
      total++;
      if ({cpu_wait, til_gnt, til_drop, cpu_gnt} !== 4'b1100) begin
        bad++;
        $display("[TB] FAIL starve_wait_%0d: got %b want 1100", k, {cpu_wait, til_gnt, til_drop, cpu_gnt});
      end
      @(negedge clk);
    end
    #1;
    total++;
    if ({cpu_gnt, til_drop, til_gnt, cpu_wait} !== 4'b1100 || ram_addr !== 16'h4000) begin
      bad++;
      $display("[TB] FAIL starve_preempt: got %b addr %h want 1100 addr 4000",
               {cpu_gnt, til_drop, til_gnt, cpu_wait}, ram_addr);
    end
    @(negedge clk);
    cpu_req = 1'b0; #1;
    total++;
    if (cpu_rvalid !== 1'b1 || rdata !== ref_mem[16'h4000] || til_gnt !== 1'b1 ||
        dut.starve_cnt !== 8'd0) begin
      bad++;
      $display("[TB] FAIL starve_after: cpu_rvalid %b rdata %h til_gnt %b cnt %0d want 1 %h 1 0",
               cpu_rvalid, rdata, til_gnt, dut.starve_cnt, ref_mem[16'h4000]);
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
  endtask

  task automatic test_sprite_vs_starved();
    drive(0, 1, 1, 0, 0, 16'h0200, 16'h4001, 8'h00);
    repeat (LIMIT) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      spr_req = 1'b1; spr_addr = 16'h6000 + 16'(k); #1;
      total++;
      if ({spr_gnt, cpu_gnt, cpu_wait, til_drop, til_gnt} !== 5'b10100) begin
        bad++;
        $display("[TB] FAIL spr_vs_starved_%0d: got %b want 10100", k,
                 {spr_gnt, cpu_gnt, cpu_wait, til_drop, til_gnt});
      end
      @(negedge clk);
    end
    spr_req = 1'b0; #1;
    total++;
    if ({cpu_gnt, til_drop, til_gnt} !== 3'b110) begin
      bad++;
      $display("[TB] FAIL starved_cpu_after_spr: got %b want 110", {cpu_gnt, til_drop, til_gnt});
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
  endtask

  task automatic test_write_read();
    drive(0, 0, 1, 1, 0, 0, 16'h4C00, 8'hA5); #1;
    total++;
    if ({cpu_gnt, ram_we, ram_en} !== 3'b111 || ram_wdata !== 8'hA5 || ram_addr !== 16'h4C00) begin
      bad++;
      $display("[TB] FAIL write_cycle: got %b wdata %h addr %h want 111 A5 4C00",
               {cpu_gnt, ram_we, ram_en}, ram_wdata, ram_addr);
    end
    ref_mem[16'h4C00] = 8'hA5;
    @(negedge clk);
    drive(0, 0, 1, 0, 0, 0, 16'h4C00, 8'h00); #1;
    total++;
    if ({spr_rvalid, til_rvalid, cpu_rvalid} !== 3'b000 || cpu_gnt !== 1'b1 || ram_we !== 1'b0) begin
      bad++;
      $display("[TB] FAIL write_no_rvalid: rvalid %b gnt %b we %b want 000 1 0",
               {spr_rvalid, til_rvalid, cpu_rvalid}, cpu_gnt, ram_we);
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0); #1;
    total++;
    if (cpu_rvalid !== 1'b1 || rdata !== 8'hA5) begin
      bad++;
      $display("[TB] FAIL read_back: cpu_rvalid %b rdata %h want 1 A5", cpu_rvalid, rdata);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_read();
    drive(0, 1, 0, 0, 0, 16'h1234, 0, 0); #1;
    total++;
    if (til_gnt !== 1'b1) begin
      bad++;
      $display("[TB] FAIL mid_read_grant: til_gnt %b want 1", til_gnt);
    end
    @(negedge clk);
    rst = 1'b1; til_req = 1'b0; #1;
    total++;
    if (til_rvalid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL mid_read_rst: til_rvalid %b want 0", til_rvalid);
    end
    @(negedge clk);
    rst = 1'b0; #1;
    total++;
    if ({spr_rvalid, til_rvalid, cpu_rvalid} !== 3'b000) begin
      bad++;
      $display("[TB] FAIL mid_read_after: rvalid %b want 000", {spr_rvalid, til_rvalid, cpu_rvalid});
    end
    @(negedge clk);
  endtask

  // Reference: pick one winner per cycle from the arbitration rules, track
  // consecutive denied CPU cycles, and remember which read returns next.
  task automatic test_random();
    int            starve = 0;
    int            win;
    int            exp_owner = 0;
    logic [DW-1:0] exp_data = '0;
    logic          cpu_pend = 1'b0;
    logic [AW-1:0] exp_addr;
    logic [6:0]    exp_ctl;
    logic [2:0]    exp_rv;
    for (int cyc = 0; cyc < 400; cyc++) begin
      spr_req  = ($urandom % 4) == 0;
      til_req  = ($urandom % 2) == 0;
      spr_addr = 16'h4000 + 16'($urandom_range(0, 15));
      til_addr = 16'h4000 + 16'($urandom_range(0, 15));
      if (!cpu_pend) begin
        cpu_req   = ($urandom % 3) == 0;
        cpu_we    = $urandom % 2;
        cpu_addr  = 16'h4000 + 16'($urandom_range(0, 15));
        cpu_wdata = 8'($urandom);
      end
      #1;
      exp_rv = (exp_owner == 1) ? 3'b100 : (exp_owner == 2) ? 3'b010 :
               (exp_owner == 3) ? 3'b001 : 3'b000;
      total++;
      if ({spr_rvalid, til_rvalid, cpu_rvalid} !== exp_rv) begin
        bad++;
        $display("[TB] FAIL rnd_rvalid cyc %0d: got %b want %b", cyc,
                 {spr_rvalid, til_rvalid, cpu_rvalid}, exp_rv);
      end
      if (exp_owner != 0) begin
        total++;
        if (rdata !== exp_data) begin
          bad++;
          $display("[TB] FAIL rnd_rdata cyc %0d: got %h want %h", cyc, rdata, exp_data);
        end
      end
      if (spr_req) win = 1;
      else if (cpu_req && starve == LIMIT) win = 3;
      else if (til_req) win = 2;
      else if (cpu_req) win = 3;
      else win = 0;
      exp_addr = (win == 1) ? spr_addr : (win == 2) ? til_addr : (win == 3) ? cpu_addr : '0;
      exp_ctl  = {win == 1, win == 2, win == 3, win == 3 && til_req, cpu_req && win != 3,
                  win != 0, win == 3 && cpu_we};
      total++;
      if ({spr_gnt, til_gnt, cpu_gnt, til_drop, cpu_wait, ram_en, ram_we} !== exp_ctl ||
          ram_addr !== exp_addr || ram_wdata !== ((win == 3) ? cpu_wdata : 8'h00)) begin
        bad++;
        $display("[TB] FAIL rnd_grant cyc %0d: got %b %h %h want %b %h %h", cyc,
                 {spr_gnt, til_gnt, cpu_gnt, til_drop, cpu_wait, ram_en, ram_we}, ram_addr,
                 ram_wdata, exp_ctl, exp_addr, (win == 3) ? cpu_wdata : 8'h00);
      end
      if (win == 3 && cpu_we) begin
        ref_mem[cpu_addr] = cpu_wdata;
        exp_owner = 0;
      end else begin
        exp_owner = win;
        if (win != 0) exp_data = ref_mem[exp_addr];
      end
      cpu_pend = cpu_req && win != 3;
      starve   = cpu_pend ? ((starve < LIMIT) ? starve + 1 : LIMIT) : 0;
      @(negedge clk);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) begin
      mem[i]     = 8'(i) ^ 8'(i >> 8) ^ 8'h3C;
      ref_mem[i] = 8'(i) ^ 8'(i >> 8) ^ 8'h3C;
    end
    ram_din = '0;
    test_reset();
    test_priority();
    test_starvation();
    test_sprite_vs_starved();
    test_write_read();
    test_reset_mid_read();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
